// File: rtl/hca_pkg.sv
// Shared types and helpers for the Han-Carlson pipelined subtractor.
// Default widths, generate/propagate pair type and level-count helper.
package hca_pkg;

    localparam int HCA_XW = 15;
    localparam int HCA_YW = 12;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/hca_pipe_subtractor_if.sv
// Valid/ready operand and result streams of the pipelined subtractor.
// master drives operands and out_ready; slave is the subtractor.
interface hca_pipe_subtractor_if import hca_pkg::*; #(
    parameter int XW = HCA_XW,
    parameter int YW = HCA_YW
);

    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] d;
    logic          borrow;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, d, borrow
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, d, borrow
    );

endinterface

// File: rtl/hca_carry_cell.sv
// Prefix carry operator; hi is the higher-index group, lo the lower.
// Go = Ghi | (Glo & Phi), Po = Phi & Plo.
module hca_carry_cell import hca_pkg::*; (
    input  gp_t i_hi,
    input  gp_t i_lo,
    output gp_t o_gp
);

    assign o_gp.g = i_hi.g | (i_lo.g & i_hi.p);
    assign o_gp.p = i_hi.p & i_lo.p;

endmodule

// File: rtl/hca_pipe_subtractor.sv
// 3-stage Han-Carlson subtractor D = X + ~Z + 1 with borrow flag.
// Define HCA_SUB_SAT_EN to clamp d to 0 whenever borrow is set.
module hca_pipe_subtractor import hca_pkg::*; #(
    parameter int XW = HCA_XW,
    parameter int YW = HCA_YW
) (
    input logic                  clk,
    input logic                  rst,
    hca_pipe_subtractor_if.slave s
);

    localparam int LV  = ceil_log2(XW);
    localparam int S2L = (LV < 3) ? LV : 3;

    if (YW > XW) begin : g_width_chk
        $error("hca_pipe_subtractor: YW must not exceed XW");
    end

    logic          w_en;
    logic [XW-1:0] w_z;
    logic [XW-1:0] w_p0;
    logic [XW-1:0] w_g0;
    logic [XW-1:0] w_d;
    logic [XW-1:0] w_dq;
    logic          w_b;

    logic          r_v1;
    logic          r_v2;
    logic          r_v3;
    logic [XW-1:0] r_s1_g;
    logic [XW-1:0] r_s1_p;
    logic [XW-1:0] r_s2_p0;
    gp_t           r_s2 [XW];
    logic [XW-1:0] r_d;
    logic          r_borrow;

    // w_lv[l] is the output of prefix level l; w_in[l-1] feeds level l
    gp_t w_lv  [LV+1][XW];
    gp_t w_in  [LV+1][XW];
    gp_t w_fin [XW];

    assign w_en       = ~r_v3 | s.out_ready;
    assign s.in_ready = w_en;
    assign s.out_valid = r_v3;
    assign s.d        = r_d;
    assign s.borrow   = r_borrow;

    assign w_z  = XW'(s.y);
    assign w_p0 = s.x ^ ~w_z;
    assign w_g0 = s.x & ~w_z;

    for (genvar i = 0; i < XW; i++) begin : g_lv0
        assign w_lv[0][i] = '{g: r_s1_g[i], p: r_s1_p[i]};
    end

    for (genvar l = 1; l <= LV + 1; l++) begin : g_in
        if (l == S2L + 1) begin : g_reg
            assign w_in[l-1] = r_s2;
        end else begin : g_comb
            assign w_in[l-1] = w_lv[l-1];
        end
    end

    for (genvar l = 1; l <= LV; l++) begin : g_lv
        localparam int SP = 1 << (l - 1);
        for (genvar i = 0; i < XW; i++) begin : g_bit
            if ((i % 2 == 1) && (i >= SP)) begin : g_op
                hca_carry_cell u_cell (
                    .i_hi (w_in[l-1][i]),
                    .i_lo (w_in[l-1][i-SP]),
                    .o_gp (w_lv[l][i])
                );
            end else begin : g_pass
                assign w_lv[l][i] = w_in[l-1][i];
            end
        end
    end

    // even bits pick up the completed prefix of their odd neighbour
    for (genvar i = 0; i < XW; i++) begin : g_fix
        if ((i % 2 == 0) && (i >= 2)) begin : g_op
            hca_carry_cell u_cell (
                .i_hi (w_in[LV][i]),
                .i_lo (w_in[LV][i-1]),
                .o_gp (w_fin[i])
            );
        end else begin : g_pass
            assign w_fin[i] = w_in[LV][i];
        end
    end

    always_comb begin
        w_d    = '0;
        w_d[0] = ~r_s2_p0[0];
        for (int i = 1; i < XW; i++) begin
            w_d[i] = (w_fin[i-1].g | w_fin[i-1].p) ^ r_s2_p0[i];
        end
        w_b = ~(w_fin[XW-1].g | w_fin[XW-1].p);
    end

`ifdef HCA_SUB_SAT_EN
    assign w_dq = w_b ? '0 : w_d;
`else
    assign w_dq = w_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_s1_g   <= '0;
            r_s1_p   <= '0;
            r_s2_p0  <= '0;
            r_s2     <= '{default: '0};
            r_d      <= '0;
            r_borrow <= 1'b0;
        end else if (w_en) begin
            r_v1     <= s.in_valid;
            r_v2     <= r_v1;
            r_v3     <= r_v2;
            r_s1_g   <= w_g0;
            r_s1_p   <= w_p0;
            r_s2_p0  <= r_s1_p;
            r_s2     <= w_lv[S2L];
            r_d      <= w_dq;
            r_borrow <= w_b;
        end
    end

endmodule

// File: tb/tb_hca_pipe_subtractor.sv
// Self-checking bench for hca_pipe_subtractor: vector table, stall,
// mid-operation reset and randomized traffic against an arithmetic model.
module tb_hca_pipe_subtractor;
    import hca_pkg::*;

`ifdef HCA_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [14:0] x;
        logic [11:0] y;
        logic [14:0] d;
        logic        b;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;
    int n_out  = 0;

    logic [15:0] exp_q [$];
    logic        hold_v = 1'b0;
    logic [14:0] hold_d;
    logic        hold_b;
    bit          rnd_done;
    vec_t        tbl [10];

    hca_pipe_subtractor_if ifc ();

    hca_pipe_subtractor dut (
        .clk (clk),
        .rst (rst),
        .s   (ifc)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(input logic [14:0] xv,
                                          input logic [11:0] yv);
        int          diff;
        logic        b;
        logic [14:0] dv;
        diff = int'(xv) - int'(yv);
        b    = (diff < 0);
        dv   = 15'(b ? diff + 32768 : diff);
        if (SAT && b) dv = '0;
        return {b, dv};
    endfunction

    // called at posedge+#1; returns at posedge+#1 right after acceptance
    task automatic send(input logic [14:0] xv, input logic [11:0] yv);
        int n;
        n = 0;
        ifc.in_valid = 1'b1;
        ifc.x = xv;
        ifc.y = yv;
        @(negedge clk);
        while (!ifc.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard: transfers are sampled mid-cycle, committed at next edge
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(ifc.out_valid), 32'd1);
                check("hold_d", 32'(ifc.d), 32'(hold_d));
                check("hold_b", 32'(ifc.borrow), 32'(hold_b));
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_d", 32'(ifc.d), 32'(e[14:0]));
                    check("out_b", 32'(ifc.borrow), 32'(e[15]));
                    n_out++;
                end
            end
            if (ifc.in_valid && ifc.in_ready)
                exp_q.push_back(model(ifc.x, ifc.y));
            hold_v = ifc.out_valid && !ifc.out_ready;
            hold_d = ifc.d;
            hold_b = ifc.borrow;
        end
    end

    initial begin
        logic [14:0] xv;
        logic [11:0] yv;
        int          base;

        tbl[0] = '{15'd100,   12'd37,   15'd63,    1'b0};
        tbl[1] = '{15'd0,     12'd1,    15'h7FFF,  1'b1};
        tbl[2] = '{15'd32767, 12'd4095, 15'd28672, 1'b0};
        tbl[3] = '{15'd4095,  12'd4095, 15'd0,     1'b0};
        tbl[4] = '{15'd5,     12'd4095, 15'd28678, 1'b1};
        tbl[5] = '{15'd10,    12'd3,    15'd7,     1'b0};
        tbl[6] = '{15'd4096,  12'd4095, 15'd1,     1'b0};
        tbl[7] = '{15'd0,     12'd0,    15'd0,     1'b0};
        tbl[8] = '{15'd12345, 12'd678,  15'd11667, 1'b0};
        tbl[9] = '{15'd1000,  12'd4095, 15'd29673, 1'b1};

        // reset held two cycles with operands offered
        ifc.in_valid  = 1'b1;
        ifc.x         = 15'd123;
        ifc.y         = 12'd4;
        ifc.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_valid", 32'(ifc.out_valid), 32'd0);
            check("rst_d", 32'(ifc.d), 32'd0);
            check("rst_b", 32'(ifc.borrow), 32'd0);
        end
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("rst_quiet", 32'(ifc.out_valid), 32'd0);
        end

        // directed vectors with exact latency
        for (int k = 0; k < 10; k++) begin
            send(tbl[k].x, tbl[k].y);
            check("lat0", 32'(ifc.out_valid), 32'd0);
            @(posedge clk);
            #1;
            check("lat1", 32'(ifc.out_valid), 32'd0);
            @(posedge clk);
            #1;
            check("lat2_valid", 32'(ifc.out_valid), 32'd1);
            check("tbl_d", 32'(ifc.d),
                  32'((SAT && tbl[k].b) ? 15'd0 : tbl[k].d));
            check("tbl_b", 32'(ifc.borrow), 32'(tbl[k].b));
        end
        @(posedge clk);
        #1;

        // back-to-back stream with out_ready low in cycles 4..9
        base = n_out;
        fork
            begin
                for (int k = 1; k <= 6; k++)
                    send(15'(k * 1000), 12'(k));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                ifc.out_ready = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
                    check("bp_valid", 32'(ifc.out_valid), 32'd1);
                    @(posedge clk);
                    #1;
                end
                ifc.out_ready = 1'b1;
            end
        join
        drain(50);
        check("bp_count", 32'(n_out - base), 32'd6);

        // reset with three pairs in flight
        for (int k = 0; k < 3; k++)
            send(15'(500 + k), 12'(k));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mr_valid", 32'(ifc.out_valid), 32'd0);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("mr_quiet", 32'(ifc.out_valid), 32'd0);
        end
        send(15'd10, 12'd3);
        @(posedge clk);
        #1;
        check("mr_lat1", 32'(ifc.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("mr_valid2", 32'(ifc.out_valid), 32'd1);
        check("mr_d", 32'(ifc.d), 32'd7);
        drain(20);

        // randomized traffic with random backpressure
        base = n_out;
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    xv = 15'($urandom_range(0, 32767));
                    yv = 12'($urandom_range(0, 4095));
                    if (k % 7 == 0) xv = 15'(yv);
                    if (k % 11 == 0) xv = 15'($urandom_range(0, 4095));
                    send(xv, yv);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    ifc.out_ready = ($urandom_range(0, 3) != 0);
                end
                ifc.out_ready = 1'b1;
            end
        join
        drain(200);
        check("rnd_count", 32'(n_out - base), 32'd200);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
